seg_event_counter: RTL and testbench

Per-segment event counter that produces the six 5-bit `segNcountin` values consumed by the 640x480 VGA renderer. It synchronises six raw event lines, counts rising edges per segment over a fixed measurement window with saturation, and holds each finished window's result in a pending buffer. The pending result is transferred to the output registers only at the start of a vsync pulse, so the renderer never sees counts change mid-frame.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_sync_edge.sv | 37 +++
 rtl/seg_event_counter.sv | 135 +++++++++++++
 tb/tb_seg_event_counter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, pending-buffer state type and saturating increment
// for the per-segment event counter.
package seg_pkg;

    localparam int NUM_SEGS      = 6;
    localparam int CNT_W_DEFAULT = 5;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;

    // Adds one when inc is set, but holds at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic        inc,
        input logic [31:0] max_val
    );
        logic [31:0] res;
        if (inc && (val < max_val)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_sync_edge.sv
// One raw event line: two-flop synchroniser followed by a registered
// rising-edge detector (one-cycle pulse per clean low-to-high transition).
module seg_sync_edge (
    input  logic dclk,
    input  logic clr,
    input  logic d,
    output logic rise
);

    logic s1_q, s2_q, s3_q, rise_q;
    logic s1_d, s2_d, s3_d, rise_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_d = s2_q & ~s3_q;
    end

    // s1/s2 form the synchroniser; s3 is the delayed copy for edge detection.
    always_ff @(posedge dclk) begin
        if (clr) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/seg_event_counter.sv
// Counts synchronised rising edges per segment over a fixed window and
// releases each finished window's counts to the display only on a vsync fall.
module seg_event_counter
    import seg_pkg::*;
#(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic                dclk,
    input  logic                clr,
    input  logic [NUM_SEGS-1:0] seg_in,
    input  logic                vsync_in,
    output logic [CNT_W-1:0]    seg1countout,
    output logic [CNT_W-1:0]    seg2countout,
    output logic [CNT_W-1:0]    seg3countout,
    output logic [CNT_W-1:0]    seg4countout,
    output logic [CNT_W-1:0]    seg5countout,
    output logic [CNT_W-1:0]    seg6countout,
    output logic                window_done,
    output logic                overrun
);

    localparam int              WC_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [31:0]     SAT_MAX = 32'((1 << CNT_W) - 1);

    logic [NUM_SEGS-1:0]            ev;
    logic [WC_W-1:0]                wcnt_q, wcnt_d;
    logic [NUM_SEGS-1:0][CNT_W-1:0] acc_q, acc_d;
    logic [NUM_SEGS-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NUM_SEGS-1:0][CNT_W-1:0] out_q, out_d;
    pend_state_e                    state_q, state_d;
    logic                           vs_prev_q, vs_prev_d;
    logic                           window_done_q, window_done_d;
    logic                           overrun_q, overrun_d;
    logic                           close;
    logic                           vs_fall;

    for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
        seg_sync_edge u_sync (
            .dclk (dclk),
            .clr  (clr),
            .d    (seg_in[g]),
            .rise (ev[g])
        );
    end

    always_comb begin
        close         = (wcnt_q == WC_LAST);
        vs_fall       = vs_prev_q & ~vsync_in;
        vs_prev_d     = vsync_in;
        window_done_d = close;
        state_d       = state_q;
        pend_d        = pend_q;
        out_d         = out_q;
        overrun_d     = overrun_q;

        if (close) begin
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + WC_W'(1);
        end

        // An event landing on the close cycle still belongs to the closing window.
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (close) begin
                pend_d[i] = CNT_W'(sat_inc(32'(acc_q[i]), ev[i], SAT_MAX));
                acc_d[i]  = '0;
            end else begin
                acc_d[i]  = CNT_W'(sat_inc(32'(acc_q[i]), ev[i], SAT_MAX));
            end
        end

        case (state_q)
            PEND_EMPTY: begin
                if (close) begin
                    state_d = PEND_FULL;
                end else begin
                    state_d = PEND_EMPTY;
                end
            end
            PEND_FULL: begin
                // A display on the same cycle as a close consumes the old result, so no overrun.
                if (vs_fall) begin
                    out_d = pend_q;
                    if (close) begin
                        state_d = PEND_FULL;
                    end else begin
                        state_d = PEND_EMPTY;
                    end
                end else if (close) begin
                    overrun_d = 1'b1;
                    state_d   = PEND_FULL;
                end else begin
                    state_d   = PEND_FULL;
                end
            end
            default: begin
                state_d = PEND_EMPTY;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            wcnt_q        <= '0;
            acc_q         <= '0;
            pend_q        <= '0;
            out_q         <= '0;
            state_q       <= PEND_EMPTY;
            vs_prev_q     <= 1'b0;
            window_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            acc_q         <= acc_d;
            pend_q        <= pend_d;
            out_q         <= out_d;
            state_q       <= state_d;
            vs_prev_q     <= vs_prev_d;
            window_done_q <= window_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign seg1countout = out_q[0];
    assign seg2countout = out_q[1];
    assign seg3countout = out_q[2];
    assign seg4countout = out_q[3];
    assign seg5countout = out_q[4];
    assign seg6countout = out_q[5];
    assign window_done  = window_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_seg_event_counter.sv
// Self-checking bench for seg_event_counter: directed scenarios with fixed
// expected counts plus a randomized run against an event-level reference model.
`timescale 1ns/1ps
module tb_seg_event_counter;

    localparam int WIN  = 100;
    localparam int SATV = 31;
    localparam int NSEG = 6;

    logic       dclk = 1'b0;
    logic       clr;
    logic [5:0] seg_in;
    logic       vsync_in;
    logic [4:0] seg1countout, seg2countout, seg3countout;
    logic [4:0] seg4countout, seg5countout, seg6countout;
    logic       window_done;
    logic       overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Pulse generators: per segment, count of pulses left, high/low widths, phase.
    int g_cnt[NSEG];
    int g_hi[NSEG];
    int g_lo[NSEG];
    int g_ph[NSEG];
    bit rnd_mode;
    bit vs_auto;
    int vs_phase;

    // Reference model state.
    int         m_n;
    logic [5:0] m_h1, m_h2, m_h3, m_h4;
    logic       m_vs_prev;
    int         m_acc[NSEG];
    int         m_pend[NSEG];
    int         m_out[NSEG];
    bit         m_valid, m_wd, m_ov;

    seg_event_counter #(.WINDOW_CYCLES(WIN), .CNT_W(5)) dut (
        .dclk         (dclk),
        .clr          (clr),
        .seg_in       (seg_in),
        .vsync_in     (vsync_in),
        .seg1countout (seg1countout),
        .seg2countout (seg2countout),
        .seg3countout (seg3countout),
        .seg4countout (seg4countout),
        .seg5countout (seg5countout),
        .seg6countout (seg6countout),
        .window_done  (window_done),
        .overrun      (overrun)
    );

    always #20 dclk = ~dclk;

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model of one clock edge from the current inputs: an input rise is counted
    // three edges after it is sampled; windows close every WIN-th edge after clr.
    function automatic void model_step();
        logic [5:0] ev;
        bit close, fall, keep;
        if (clr) begin
            m_n = 0;
            m_h1 = '0; m_h2 = '0; m_h3 = '0; m_h4 = '0;
            m_vs_prev = 1'b0;
            m_valid = 1'b0; m_wd = 1'b0; m_ov = 1'b0;
            for (int i = 0; i < NSEG; i++) begin
                m_acc[i] = 0; m_pend[i] = 0; m_out[i] = 0;
            end
        end else begin
            ev = m_h3 & ~m_h4;
            m_h4 = m_h3; m_h3 = m_h2; m_h2 = m_h1; m_h1 = seg_in;
            close = ((m_n % WIN) == (WIN - 1));
            fall = m_vs_prev && !vsync_in;
            m_vs_prev = vsync_in;
            m_wd = close;
            if (fall && m_valid) begin
                for (int i = 0; i < NSEG; i++) m_out[i] = m_pend[i];
            end
            keep = m_valid && !fall;
            for (int i = 0; i < NSEG; i++) begin
                m_acc[i] = (m_acc[i] + int'(ev[i]) > SATV) ? SATV : m_acc[i] + int'(ev[i]);
                if (close) begin
                    m_pend[i] = m_acc[i];
                    m_acc[i]  = 0;
                end
            end
            if (close) begin
                if (keep) m_ov = 1'b1;
                m_valid = 1'b1;
            end else if (fall) begin
                m_valid = 1'b0;
            end
            m_n++;
        end
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NSEG; i++) v[2 + 5*i +: 5] = 5'(m_out[i]);
        v[1] = m_wd;
        v[0] = m_ov;
        return v;
    endfunction

    task automatic drive_segs();
        for (int i = 0; i < NSEG; i++) begin
            if (g_cnt[i] == 0 && rnd_mode && $urandom_range(0, 7) == 0) begin
                g_cnt[i] = $urandom_range(1, 8);
                g_hi[i]  = $urandom_range(1, 4);
                g_lo[i]  = $urandom_range(1, 4);
                g_ph[i]  = 0;
            end
            if (g_cnt[i] > 0) begin
                seg_in[i] = (g_ph[i] < g_hi[i]);
                g_ph[i]++;
                if (g_ph[i] == g_hi[i] + g_lo[i]) begin
                    g_ph[i] = 0;
                    g_cnt[i]--;
                end
            end else begin
                seg_in[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge dclk);
        @(negedge dclk);
        drive_segs();
        if (vs_auto) begin
            vs_phase = (vs_phase + 1) % 250;
            vsync_in = (vs_phase >= 2);
        end
    endtask

    task automatic start_pulses(input int seg, input int cnt, input int hi, input int lo);
        g_cnt[seg] = cnt; g_hi[seg] = hi; g_lo[seg] = lo; g_ph[seg] = 0;
    endtask

    task automatic apply_reset(input int cycles);
        rnd_mode = 1'b0;
        vs_auto  = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < NSEG; i++) g_cnt[i] = 0;
        clr = 1'b1;
        repeat (cycles) tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int  waited;
        bit  seen;
        apply_reset(1);
        rnd_mode = 1'b1; vs_auto = 1'b1; vs_phase = 0;
        repeat (170) tick();
        clr = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        rnd_mode = 1'b0;
        tests_run++;
        if ({seg6countout, seg5countout, seg4countout, seg3countout, seg2countout,
             seg1countout, window_done, overrun} !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0",
                     {seg6countout, seg5countout, seg4countout, seg3countout, seg2countout,
                      seg1countout, window_done, overrun});
        end
        waited = 0; seen = 1'b0;
        while (!seen && waited < 3 * WIN) begin
            tick();
            waited++;
            if (window_done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || waited != WIN) begin
            tests_failed++;
            $display("FAIL reset_first_close: window_done after %0d cycles (seen=%0d) expected %0d",
                     waited, seen, WIN);
        end
    endtask

    task automatic test_counting();
        apply_reset(2);
        start_pulses(0, 7, 4, 4);
        start_pulses(3, 3, 4, 4);
        repeat (WIN) tick();
        tests_run++;
        if (window_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_window_done: got %b expected 1", window_done);
        end
        tests_run++;
        if ({seg6countout, seg5countout, seg4countout, seg3countout, seg2countout, seg1countout} !== 30'd0) begin
            tests_failed++;
            $display("FAIL count_hold_before_vsync: seg1=%0d seg4=%0d expected 0", seg1countout, seg4countout);
        end
        repeat (10) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg1countout !== 5'd7 || seg4countout !== 5'd3) begin
            tests_failed++;
            $display("FAIL count_values: seg1=%0d seg4=%0d expected 7 and 3", seg1countout, seg4countout);
        end
        tests_run++;
        if ({seg6countout, seg5countout, seg3countout, seg2countout} !== 20'd0) begin
            tests_failed++;
            $display("FAIL count_others: seg2=%0d seg3=%0d seg5=%0d seg6=%0d expected 0",
                     seg2countout, seg3countout, seg5countout, seg6countout);
        end
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset(2);
        start_pulses(5, 40, 1, 1);
        repeat (WIN + 5) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg6countout !== 5'd31) begin
            tests_failed++;
            $display("FAIL saturation: seg6=%0d expected 31", seg6countout);
        end
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_close_event();
        apply_reset(2);
        repeat (WIN - 5) tick();
        start_pulses(1, 1, 2, 2);
        repeat (10) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg2countout !== 5'd1) begin
            tests_failed++;
            $display("FAIL close_event_counted: seg2=%0d expected 1", seg2countout);
        end
        vsync_in = 1'b1;
        tick();
        while ((m_n % WIN) != 0) tick();
        repeat (5) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg2countout !== 5'd0) begin
            tests_failed++;
            $display("FAIL close_event_next_window: seg2=%0d expected 0", seg2countout);
        end
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        apply_reset(2);
        start_pulses(0, 2, 4, 4);
        repeat (WIN) tick();
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_first_close: got %b expected 0", overrun);
        end
        start_pulses(0, 5, 4, 4);
        repeat (WIN) tick();
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_second_close: got %b expected 1", overrun);
        end
        start_pulses(0, 9, 4, 4);
        repeat (WIN + 3) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg1countout !== 5'd9 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_newest_wins: seg1=%0d overrun=%b expected 9 and 1", seg1countout, overrun);
        end
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset(2);
        start_pulses(4, 4, 4, 4);
        repeat (WIN) tick();
        start_pulses(4, 6, 4, 4);
        repeat (WIN - 1) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg5countout !== 5'd4 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_old_pend: seg5=%0d overrun=%b expected 4 and 0", seg5countout, overrun);
        end
        tick();
        vsync_in = 1'b1;
        repeat (20) tick();
        vsync_in = 1'b0;
        tick();
        tests_run++;
        if (seg5countout !== 5'd6 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_new_pend: seg5=%0d overrun=%b expected 6 and 0", seg5countout, overrun);
        end
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] obs;
        logic [31:0] exp_v;
        apply_reset(2);
        rnd_mode = 1'b1; vs_auto = 1'b1; vs_phase = 0;
        for (int c = 0; c < 2500; c++) begin
            clr = ($urandom_range(0, 899) == 0);
            tick();
            obs   = {seg6countout, seg5countout, seg4countout, seg3countout, seg2countout,
                     seg1countout, window_done, overrun};
            exp_v = model_vec();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                if (tests_failed < 20)
                    $display("FAIL random_cycle_%0d: got %h expected %h", c, obs, exp_v);
            end
        end
        clr = 1'b0;
        rnd_mode = 1'b0;
    endtask

    initial begin
        clr = 1'b1; seg_in = '0; vsync_in = 1'b1;
        rnd_mode = 1'b0; vs_auto = 1'b0; vs_phase = 0;
        for (int i = 0; i < NSEG; i++) begin
            g_cnt[i] = 0; g_hi[i] = 1; g_lo[i] = 1; g_ph[i] = 0;
        end
        @(negedge dclk);
        test_reset();
        test_counting();
        test_saturation();
        test_close_event();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
